// File: rtl/debug_step_controller.sv
// Debug initiator for the CPU phase sequencer: halt/run/step control, a single
// address breakpoint, and the four-phase DEBUG_STEP_REQ/ACK handshake.
module debug_step_controller #(
    parameter int ADDR_WIDTH   = 16,
    parameter int COUNT_WIDTH  = 8,
    parameter int ACK_TIMEOUT  = 64,
    parameter bit START_HALTED = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  CMD_VALID,
    input  logic [2:0]            CMD,
    input  logic [ADDR_WIDTH-1:0] CMD_ARG,
    output logic                  CMD_READY,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic                  STOPPED,
    input  logic                  DEBUG_STEP_ACK,
    output logic                  DEBUG_STOP,
    output logic                  DEBUG_MODE,
    output logic                  DEBUG_STEP_REQ,
    output logic                  DEBUG_AT_BKP,
    output logic                  BKP_HIT,
    output logic                  STEP_DONE,
    output logic                  ERR
);

    localparam int TIMER_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] CMD_HALT    = 3'b001;
    localparam logic [2:0] CMD_RUN     = 3'b010;
    localparam logic [2:0] CMD_STEP    = 3'b011;
    localparam logic [2:0] CMD_SET_BKP = 3'b100;
    localparam logic [2:0] CMD_CLR_BKP = 3'b101;

    typedef enum logic [2:0] {
        S_RUN,
        S_HALTING,
        S_HALTED,
        S_REQ,
        S_RELEASE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [TIMER_W-1:0]     r_timer;
    logic [COUNT_WIDTH-1:0] r_steps_left;
    logic [ADDR_WIDTH-1:0]  r_bkp_addr;
    logic                   r_bkp_en;
    logic                   r_skip;
    logic                   r_at_bkp;
    logic                   r_stop;
    logic                   r_mode;
    logic                   r_req;
    logic                   r_bkp_hit;
    logic                   r_step_done;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_pc_match;
    logic [COUNT_WIDTH-1:0] w_count;
    logic                   w_run_accept;
    logic                   w_step_load;
    logic                   w_timer_clr;
    logic                   w_timer_inc;
    logic                   w_steps_clr;
    logic                   w_steps_dec;
    logic                   w_err;
    logic                   w_bkp_hit;
    logic                   w_step_done;

    assign CMD_READY  = ((r_state == S_RUN) & ~r_at_bkp) | (r_state == S_HALTED);
    assign w_accept   = CMD_VALID & CMD_READY;
    assign w_pc_match = (PC == r_bkp_addr);
    assign w_count    = CMD_ARG[COUNT_WIDTH-1:0];

    assign DEBUG_STOP     = r_stop;
    assign DEBUG_MODE     = r_mode;
    assign DEBUG_STEP_REQ = r_req;
    assign DEBUG_AT_BKP   = r_at_bkp;
    assign BKP_HIT        = r_bkp_hit;
    assign STEP_DONE      = r_step_done;
    assign ERR            = r_err;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            if (START_HALTED) r_state <= S_HALTING;
            else              r_state <= S_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_run_accept = 1'b0;
        w_step_load  = 1'b0;
        w_timer_clr  = 1'b0;
        w_timer_inc  = 1'b0;
        w_steps_clr  = 1'b0;
        w_steps_dec  = 1'b0;
        w_err        = 1'b0;
        w_bkp_hit    = 1'b0;
        w_step_done  = 1'b0;
        case (r_state)
            S_RUN: begin
                // A pending breakpoint blocks CMD_READY, so no command races it
                if (r_at_bkp) begin
                    w_next    = S_HALTING;
                    w_bkp_hit = 1'b1;
                end else if (w_accept) begin
                    if (CMD == CMD_HALT)      w_next = S_HALTING;
                    else if (CMD == CMD_STEP) w_err  = 1'b1;
                end
            end
            S_HALTING: begin
                if (STOPPED) w_next = S_HALTED;
            end
            S_HALTED: begin
                if (w_accept) begin
                    if (CMD == CMD_RUN) begin
                        w_next       = S_RUN;
                        w_run_accept = 1'b1;
                    end else if (CMD == CMD_STEP) begin
                        w_next      = S_REQ;
                        w_step_load = 1'b1;
                        w_timer_clr = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (DEBUG_STEP_ACK) begin
                    w_next = S_RELEASE;
                end else if (r_timer == TIMER_W'(ACK_TIMEOUT)) begin
                    w_next      = S_HALTED;
                    w_err       = 1'b1;
                    w_steps_clr = 1'b1;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            S_RELEASE: begin
                // Only re-request once ACK has dropped, completing the four phases
                if (!DEBUG_STEP_ACK) begin
                    if (r_steps_left <= COUNT_WIDTH'(1)) begin
                        w_next      = S_HALTED;
                        w_step_done = 1'b1;
                        w_steps_clr = 1'b1;
                    end else begin
                        w_next      = S_REQ;
                        w_steps_dec = 1'b1;
                        w_timer_clr = 1'b1;
                    end
                end
            end
            default: w_next = S_RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_stop       <= START_HALTED;
            r_mode       <= START_HALTED;
            r_req        <= 1'b0;
            r_bkp_hit    <= 1'b0;
            r_step_done  <= 1'b0;
            r_err        <= 1'b0;
            r_timer      <= '0;
            r_steps_left <= '0;
        end else begin
            r_stop      <= (w_next != S_RUN);
            r_mode      <= (w_next != S_RUN);
            r_req       <= (w_next == S_REQ);
            r_bkp_hit   <= w_bkp_hit;
            r_step_done <= w_step_done;
            r_err       <= w_err;
            if (w_timer_clr)      r_timer <= '0;
            else if (w_timer_inc) r_timer <= r_timer + TIMER_W'(1);
            if (w_step_load)      r_steps_left <= (w_count == '0) ? COUNT_WIDTH'(1) : w_count;
            else if (w_steps_clr) r_steps_left <= '0;
            else if (w_steps_dec) r_steps_left <= r_steps_left - COUNT_WIDTH'(1);
        end
    end

    // SKIP masks the match at the resume address until PC has moved away once
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_bkp_addr <= '0;
            r_bkp_en   <= 1'b0;
            r_skip     <= 1'b0;
            r_at_bkp   <= 1'b0;
        end else begin
            if (w_accept && (CMD == CMD_SET_BKP)) begin
                r_bkp_addr <= CMD_ARG;
                r_bkp_en   <= 1'b1;
            end else if (w_accept && (CMD == CMD_CLR_BKP)) begin
                r_bkp_en <= 1'b0;
            end
            if (w_run_accept)                             r_skip <= w_pc_match;
            else if (w_accept && (CMD == CMD_SET_BKP))    r_skip <= 1'b0;
            else if (!w_pc_match)                         r_skip <= 1'b0;
            if (w_run_accept) r_at_bkp <= 1'b0;
            else              r_at_bkp <= r_bkp_en & w_pc_match & ~r_skip;
        end
    end

endmodule

// File: tb/tb_debug_step_controller.sv
// Self-checking bench for debug_step_controller: randomized step counts, ACK
// latencies and breakpoint addresses checked against scenario-level expectations.
module tb_debug_step_controller;

    localparam int AW = 16;
    localparam int CW = 8;
    localparam int TO = 64;

    localparam logic [2:0] C_HALT = 3'b001;
    localparam logic [2:0] C_RUN  = 3'b010;
    localparam logic [2:0] C_STEP = 3'b011;
    localparam logic [2:0] C_SET  = 3'b100;
    localparam logic [2:0] C_CLR  = 3'b101;

    logic          CLK = 1'b0;
    logic          RESETN = 1'b0;
    logic          CMD_VALID = 1'b0;
    logic [2:0]    CMD = 3'b000;
    logic [AW-1:0] CMD_ARG = '0;
    logic [AW-1:0] PC = '0;
    logic          STOPPED = 1'b0;
    logic          DEBUG_STEP_ACK = 1'b0;
    logic          CMD_READY, DEBUG_STOP, DEBUG_MODE, DEBUG_STEP_REQ;
    logic          DEBUG_AT_BKP, BKP_HIT, STEP_DONE, ERR;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    debug_step_controller #(
        .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .ACK_TIMEOUT(TO), .START_HALTED(1'b0)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .CMD_VALID(CMD_VALID), .CMD(CMD), .CMD_ARG(CMD_ARG),
        .CMD_READY(CMD_READY), .PC(PC), .STOPPED(STOPPED), .DEBUG_STEP_ACK(DEBUG_STEP_ACK),
        .DEBUG_STOP(DEBUG_STOP), .DEBUG_MODE(DEBUG_MODE), .DEBUG_STEP_REQ(DEBUG_STEP_REQ),
        .DEBUG_AT_BKP(DEBUG_AT_BKP), .BKP_HIT(BKP_HIT), .STEP_DONE(STEP_DONE), .ERR(ERR)
    );

    // Bit order: STOP MODE REQ AT_BKP BKP_HIT STEP_DONE ERR READY
    function automatic logic [7:0] outs();
        return {DEBUG_STOP, DEBUG_MODE, DEBUG_STEP_REQ, DEBUG_AT_BKP,
                BKP_HIT, STEP_DONE, ERR, CMD_READY};
    endfunction

    task automatic send(input logic [2:0] c, input logic [AW-1:0] arg);
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD = c; CMD_ARG = arg;
        @(negedge CLK);
        CMD_VALID = 1'b0; CMD = 3'b000;
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (outs() !== 8'b0000_0001) begin
            errors++; $display("FAIL reset_outs got %b want %b", outs(), 8'b0000_0001);
        end
        RESETN = 1'b1;
        @(negedge CLK);
        checks++;
        if (outs() !== 8'b0000_0001) begin
            errors++; $display("FAIL reset_release got %b want %b", outs(), 8'b0000_0001);
        end
    endtask

    task automatic test_halt();
        int d;
        d = $urandom_range(1, 3);
        STOPPED = 1'b0;
        send(C_HALT, '0);
        checks++;
        if (outs() !== 8'b1100_0000) begin
            errors++; $display("FAIL halt_accept got %b want %b", outs(), 8'b1100_0000);
        end
        repeat (d) @(negedge CLK);
        checks++;
        if (outs() !== 8'b1100_0000) begin
            errors++; $display("FAIL halt_waiting got %b want %b", outs(), 8'b1100_0000);
        end
        STOPPED = 1'b1;
        @(negedge CLK);
        checks++;
        if (outs() !== 8'b1100_0001) begin
            errors++; $display("FAIL halt_halted got %b want %b", outs(), 8'b1100_0001);
        end
    endtask

    task automatic test_step(input int count, input int lat);
        int  exp_steps = (count == 0) ? 1 : count;
        int  rises = 0, pairs = 0, dones = 0, stop_low = 0, viol = 0, errs = 0, held = 0;
        int  tail_bad = 0;
        logic prev_req = 1'b0;
        bit  finished = 1'b0;
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD = C_STEP; CMD_ARG = AW'(count);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge CLK);
            CMD_VALID = 1'b0; CMD = 3'b000;
            if (DEBUG_STEP_REQ && !prev_req) begin
                rises++;
                if (DEBUG_STEP_ACK) viol++;
                held = 0;
            end
            if (!DEBUG_STOP) stop_low++;
            if (ERR) errs++;
            if (STEP_DONE) begin
                dones++;
                finished = 1'b1;
                checks++;
                if (pairs !== exp_steps || DEBUG_STEP_ACK !== 1'b0 || CMD_READY !== 1'b1) begin
                    errors++;
                    $display("FAIL step_done_point pairs %0d ack %b ready %b want pairs %0d ack 0 ready 1",
                             pairs, DEBUG_STEP_ACK, CMD_READY, exp_steps);
                end
            end
            // Sequencer: raise ACK lat cycles into REQ, drop it once REQ falls
            if (DEBUG_STEP_REQ && !DEBUG_STEP_ACK) begin
                held++;
                if (held >= lat) begin
                    DEBUG_STEP_ACK = 1'b1;
                    pairs++;
                end
            end else if (!DEBUG_STEP_REQ && DEBUG_STEP_ACK) begin
                DEBUG_STEP_ACK = 1'b0;
            end
            prev_req = DEBUG_STEP_REQ;
        end
        repeat (3) begin
            @(negedge CLK);
            if (STEP_DONE || DEBUG_STEP_REQ || !DEBUG_STOP || !CMD_READY) tail_bad++;
        end
        checks++;
        if (rises !== exp_steps) begin
            errors++; $display("FAIL step_req_count got %0d want %0d (arg %0d)", rises, exp_steps, count);
        end
        checks++;
        if (dones !== 1) begin
            errors++; $display("FAIL step_done_count got %0d want 1", dones);
        end
        checks++;
        if (stop_low !== 0 || viol !== 0 || errs !== 0 || tail_bad !== 0) begin
            errors++;
            $display("FAIL step_protocol stop_low %0d req_while_ack %0d err %0d tail %0d want all 0",
                     stop_low, viol, errs, tail_bad);
        end
    endtask

    task automatic test_step_timeout(input int count);
        int req_high = 0, errs = 0;
        bit fell = 1'b0;
        DEBUG_STEP_ACK = 1'b0;
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD = C_STEP; CMD_ARG = AW'(count);
        for (int cyc = 0; cyc < 300 && !fell; cyc++) begin
            @(negedge CLK);
            CMD_VALID = 1'b0; CMD = 3'b000;
            if (ERR) errs++;
            if (DEBUG_STEP_REQ) req_high++;
            else if (req_high > 0) begin
                fell = 1'b1;
                checks++;
                if (outs() !== 8'b1100_0011) begin
                    errors++; $display("FAIL timeout_abort got %b want %b", outs(), 8'b1100_0011);
                end
            end
        end
        checks++;
        if (req_high !== TO + 1) begin
            errors++; $display("FAIL timeout_req_cycles got %0d want %0d", req_high, TO + 1);
        end
        @(negedge CLK);
        if (ERR) errs++;
        checks++;
        if (errs !== 1 || outs() !== 8'b1100_0001) begin
            errors++; $display("FAIL timeout_after err_pulses %0d outs %b want 1 and %b",
                               errs, outs(), 8'b1100_0001);
        end
    endtask

    task automatic test_breakpoint(input logic [AW-1:0] a);
        int bad = 0;
        logic [AW-1:0] p;
        PC = a - AW'(5);
        send(C_SET, a);
        STOPPED = 1'b0;
        send(C_RUN, '0);
        checks++;
        if (outs() !== 8'b0000_0001) begin
            errors++; $display("FAIL bkp_run got %b want %b", outs(), 8'b0000_0001);
        end
        for (int k = 3; k >= 1; k--) begin
            p = a - AW'(k);
            PC = p;
            @(negedge CLK);
            if (outs() !== 8'b0000_0001) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL bkp_approach bad_cycles %0d want 0", bad);
        end
        PC = a;
        @(negedge CLK);
        checks++;
        if (outs() !== 8'b0001_0000) begin
            errors++; $display("FAIL bkp_match got %b want %b", outs(), 8'b0001_0000);
        end
        // This command must lose to the pending breakpoint
        CMD_VALID = 1'b1; CMD = C_CLR;
        @(negedge CLK);
        CMD_VALID = 1'b0; CMD = 3'b000;
        checks++;
        if (outs() !== 8'b1101_1000) begin
            errors++; $display("FAIL bkp_hit got %b want %b", outs(), 8'b1101_1000);
        end
        @(negedge CLK);
        checks++;
        if (outs() !== 8'b1101_0000) begin
            errors++; $display("FAIL bkp_hit_pulse got %b want %b", outs(), 8'b1101_0000);
        end
        STOPPED = 1'b1;
        @(negedge CLK);
        checks++;
        if (outs() !== 8'b1101_0001) begin
            errors++; $display("FAIL bkp_halted got %b want %b", outs(), 8'b1101_0001);
        end
    endtask

    task automatic test_resume(input logic [AW-1:0] a);
        int bad = 0;
        int hold = $urandom_range(2, 4);
        PC = a;
        STOPPED = 1'b0;
        send(C_RUN, '0);
        checks++;
        if (outs() !== 8'b0000_0001) begin
            errors++; $display("FAIL resume_run got %b want %b", outs(), 8'b0000_0001);
        end
        repeat (hold) begin
            @(negedge CLK);
            if (outs() !== 8'b0000_0001) bad++;
        end
        PC = a + AW'(1);
        @(negedge CLK);
        if (outs() !== 8'b0000_0001) bad++;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL resume_skip bad_cycles %0d want 0", bad);
        end
        PC = a;
        @(negedge CLK);
        checks++;
        if (outs() !== 8'b0001_0000) begin
            errors++; $display("FAIL resume_rematch got %b want %b", outs(), 8'b0001_0000);
        end
        @(negedge CLK);
        checks++;
        if (outs() !== 8'b1101_1000) begin
            errors++; $display("FAIL resume_rehit got %b want %b", outs(), 8'b1101_1000);
        end
        STOPPED = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_clr_bkp(input logic [AW-1:0] a);
        int bad = 0;
        logic [AW-1:0] walk [4];
        walk[0] = a - AW'(1); walk[1] = a; walk[2] = a + AW'(1); walk[3] = a;
        send(C_CLR, '0);
        STOPPED = 1'b0;
        send(C_RUN, '0);
        for (int k = 0; k < 4; k++) begin
            PC = walk[k];
            @(negedge CLK);
            if (outs() !== 8'b0000_0001) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL clr_bkp_no_match bad_cycles %0d want 0", bad);
        end
        STOPPED = 1'b1;
        send(C_HALT, '0);
        @(negedge CLK);
        checks++;
        if (outs() !== 8'b1100_0001) begin
            errors++; $display("FAIL clr_bkp_halt got %b want %b", outs(), 8'b1100_0001);
        end
    endtask

    task automatic test_step_in_run();
        STOPPED = 1'b0;
        send(C_RUN, '0);
        send(C_STEP, AW'(3));
        checks++;
        if (outs() !== 8'b0000_0011) begin
            errors++; $display("FAIL run_step_err got %b want %b", outs(), 8'b0000_0011);
        end
        @(negedge CLK);
        checks++;
        if (outs() !== 8'b0000_0001) begin
            errors++; $display("FAIL run_step_after got %b want %b", outs(), 8'b0000_0001);
        end
        STOPPED = 1'b1;
        send(C_HALT, '0);
        @(negedge CLK);
        checks++;
        if (outs() !== 8'b1100_0001) begin
            errors++; $display("FAIL run_step_rehalt got %b want %b", outs(), 8'b1100_0001);
        end
    endtask

    task automatic test_reset_mid_handshake(input logic [AW-1:0] a);
        int bad = 0;
        bit seen = 1'b0;
        PC = a;
        send(C_SET, a);
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD = C_STEP; CMD_ARG = AW'(5);
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge CLK);
            CMD_VALID = 1'b0; CMD = 3'b000;
            if (DEBUG_STEP_REQ) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL midreset_req_rise got 0 want 1");
        end
        DEBUG_STEP_ACK = 1'b1;
        #2 RESETN = 1'b0;
        #1;
        checks++;
        if (outs() !== 8'b0000_0001) begin
            errors++; $display("FAIL midreset_async got %b want %b", outs(), 8'b0000_0001);
        end
        repeat (2) @(negedge CLK);
        DEBUG_STEP_ACK = 1'b0;
        STOPPED = 1'b0;
        RESETN = 1'b1;
        repeat (20) begin
            @(negedge CLK);
            if (outs() !== 8'b0000_0001) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL midreset_after bad_cycles %0d want 0", bad);
        end
    endtask

    initial begin
        logic [AW-1:0] ra;
        ra = AW'($urandom_range(16, 16'hFFF0));
        test_reset();
        test_halt();
        test_step(3, 4);
        repeat (4) test_step($urandom_range(0, 6), $urandom_range(1, 5));
        test_step_timeout($urandom_range(1, 5));
        test_step(2, 2);
        test_breakpoint(16'h0040);
        test_resume(16'h0040);
        test_breakpoint(ra);
        test_resume(ra);
        test_clr_bkp(ra);
        test_step_in_run();
        test_reset_mid_handshake(ra);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
